cpu_instr_sequencer: RTL and testbench

- Instruction-issuing controller for the CPU datapath. It is the initiator side of the ALU opcode/flag interface.
- Fetches 16-bit instruction words from a synchronous program/data memory and decodes them into enum_alu_opcode_t operations.
- LOADA/LOADB/LOADC fill operand registers from memory. All other opcodes are issued to the ALU over a valid/ready request with a done-pulse response; the result lands in C and the struct_alu_flag_t flags are latched.

---
 rtl/cpu_instr_sequencer.sv | 233 +++++++++++++++++++++++
 tb/tb_cpu_instr_sequencer.sv | 362 ++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cpu_instr_sequencer.sv
// cpu_instr_sequencer: fetches 16-bit instruction words from a synchronous
// memory and either loads an operand register (LOADA/LOADB/LOADC) or issues
// the opcode to the ALU over a valid/ready request with a done-pulse reply.
// ALU results land in reg_c and the ALU flags are latched on alu_done only.
//
// Build macro: CPU_STORE_EN -- when defined, WRITEBACK also stores the ALU
// result to memory at the instruction's operand address. When undefined,
// mem_wr_en and mem_wdata are held at 0.
module cpu_instr_sequencer #(
  parameter int DATA_WIDTH    = 16,
  parameter int ADDRESS_WIDTH = 12,
  parameter int OPCODE        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic [ADDRESS_WIDTH-1:0] prog_len,
  output logic                     busy,
  output logic                     done,
  output logic [ADDRESS_WIDTH-1:0] mem_addr,
  output logic                     mem_rd_en,
  input  logic [DATA_WIDTH-1:0]    mem_rdata,
  output logic                     mem_wr_en,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  output logic [OPCODE-1:0]        alu_op,
  output logic [DATA_WIDTH-1:0]    alu_a,
  output logic [DATA_WIDTH-1:0]    alu_b,
  output logic                     alu_valid,
  input  logic                     alu_ready,
  input  logic                     alu_done,
  input  logic [DATA_WIDTH-1:0]    alu_result,
  input  logic [4:0]               alu_flags,
  output logic [DATA_WIDTH-1:0]    reg_a,
  output logic [DATA_WIDTH-1:0]    reg_b,
  output logic [DATA_WIDTH-1:0]    reg_c,
  output logic [4:0]               flags,
  output logic [ADDRESS_WIDTH-1:0] pc
);

  typedef enum logic [3:0] {
    ALU_ADD   = 4'h0,
    ALU_SUB   = 4'h1,
    ALU_AND   = 4'h2,
    ALU_OR    = 4'h3,
    ALU_XOR   = 4'h4,
    ALU_NOT   = 4'h5,
    ALU_SHL   = 4'h6,
    ALU_SHR   = 4'h7,
    ALU_CMP   = 4'h8,
    ALU_INC   = 4'h9,
    ALU_DEC   = 4'hA,
    ALU_PASSA = 4'hB,
    ALU_PASSB = 4'hC,
    LOADA     = 4'hD,
    LOADB     = 4'hE,
    LOADC     = 4'hF
  } enum_alu_opcode_t;

  // Bit order on the 5-bit flag bus: {carry, zero, equal, larger, lower}.
  typedef struct packed {
    logic carry;
    logic zero;
    logic equal;
    logic larger;
    logic lower;
  } struct_alu_flag_t;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    FETCH      = 3'd1,
    FETCH_WAIT = 3'd2,
    DECODE     = 3'd3,
    OPER_WAIT  = 3'd4,
    EXECUTE    = 3'd5,
    ALU_WAIT   = 3'd6,
    WRITEBACK  = 3'd7
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d;
  logic [ADDRESS_WIDTH-1:0] len_q, len_d;
  logic [DATA_WIDTH-1:0]    ir_q, ir_d;
  logic [DATA_WIDTH-1:0]    reg_a_q, reg_a_d;
  logic [DATA_WIDTH-1:0]    reg_b_q, reg_b_d;
  logic [DATA_WIDTH-1:0]    reg_c_q, reg_c_d;
  struct_alu_flag_t         flags_q, flags_d;
  logic                     done_q, done_d;

  enum_alu_opcode_t         opcode;
  logic [ADDRESS_WIDTH-1:0] operand;
  logic [ADDRESS_WIDTH-1:0] pc_inc;
  logic                     is_load;
  logic                     retire;

  assign opcode  = enum_alu_opcode_t'(ir_q[DATA_WIDTH-1 -: OPCODE]);
  assign operand = ir_q[ADDRESS_WIDTH-1:0];
  assign is_load = (opcode == LOADA) || (opcode == LOADB) || (opcode == LOADC);
  // pc wraps naturally at 2^ADDRESS_WIDTH.
  assign pc_inc  = pc_q + ADDRESS_WIDTH'(1);

  assign busy   = (state_q != IDLE);
  assign done   = done_q;
  assign pc     = pc_q;
  assign reg_a  = reg_a_q;
  assign reg_b  = reg_b_q;
  assign reg_c  = reg_c_q;
  assign flags  = flags_q;
  // The request fields come straight from registers that cannot change while
  // EXECUTE waits for alu_ready, so they stay stable through the handshake.
  assign alu_op = ir_q[DATA_WIDTH-1 -: OPCODE];
  assign alu_a  = reg_a_q;
  assign alu_b  = reg_b_q;

  // Next-state, datapath updates and Moore-style memory/ALU strobes.
  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    len_d     = len_q;
    ir_d      = ir_q;
    reg_a_d   = reg_a_q;
    reg_b_d   = reg_b_q;
    reg_c_d   = reg_c_q;
    flags_d   = flags_q;
    done_d    = 1'b0;
    retire    = 1'b0;
    mem_addr  = '0;
    mem_rd_en = 1'b0;
    mem_wr_en = 1'b0;
    mem_wdata = '0;
    alu_valid = 1'b0;

    case (state_q)
      IDLE: begin
        if (start) begin
          len_d = prog_len;
          pc_d  = '0;
          if (prog_len == '0) begin
            done_d = 1'b1;
          end else begin
            state_d = FETCH;
          end
        end
      end
      FETCH: begin
        mem_rd_en = 1'b1;
        mem_addr  = pc_q;
        state_d   = FETCH_WAIT;
      end
      FETCH_WAIT: begin
        ir_d    = mem_rdata;
        state_d = DECODE;
      end
      DECODE: begin
        if (is_load) begin
          mem_rd_en = 1'b1;
          mem_addr  = operand;
          state_d   = OPER_WAIT;
        end else begin
          state_d = EXECUTE;
        end
      end
      OPER_WAIT: begin
        case (opcode)
          LOADA:   reg_a_d = mem_rdata;
          LOADB:   reg_b_d = mem_rdata;
          default: reg_c_d = mem_rdata;
        endcase
        retire = 1'b1;
      end
      EXECUTE: begin
        alu_valid = 1'b1;
        if (alu_ready) begin
          state_d = ALU_WAIT;
        end
      end
      ALU_WAIT: begin
        if (alu_done) begin
          reg_c_d = alu_result;
          flags_d = struct_alu_flag_t'(alu_flags);
          state_d = WRITEBACK;
        end
      end
      WRITEBACK: begin
`ifdef CPU_STORE_EN
        // reg_c_q holds the result captured on alu_done.
        mem_wr_en = 1'b1;
        mem_addr  = operand;
        mem_wdata = reg_c_q;
`endif
        retire = 1'b1;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    if (retire) begin
      pc_d = pc_inc;
      if (pc_inc == len_q) begin
        state_d = IDLE;
        done_d  = 1'b1;
      end else begin
        state_d = FETCH;
      end
    end
  end

  // State and architectural registers; reset clears every visible output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      pc_q    <= '0;
      len_q   <= '0;
      ir_q    <= '0;
      reg_a_q <= '0;
      reg_b_q <= '0;
      reg_c_q <= '0;
      flags_q <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      len_q   <= len_d;
      ir_q    <= ir_d;
      reg_a_q <= reg_a_d;
      reg_b_q <= reg_b_d;
      reg_c_q <= reg_c_d;
      flags_q <= flags_d;
      done_q  <= done_d;
    end
  end

endmodule

// File: tb/tb_cpu_instr_sequencer.sv
// Directed testbench for cpu_instr_sequencer with a synchronous memory model
// and a small ALU model (ADD/SUB, flags {carry,zero,equal,larger,lower}).
module tb_cpu_instr_sequencer;

  logic        clk;
  logic        rst;
  logic        start;
  logic [11:0] prog_len;
  logic        busy;
  logic        done;
  logic [11:0] mem_addr;
  logic        mem_rd_en;
  logic [15:0] mem_rdata;
  logic        mem_wr_en;
  logic [15:0] mem_wdata;
  logic [3:0]  alu_op;
  logic [15:0] alu_a;
  logic [15:0] alu_b;
  logic        alu_valid;
  logic        alu_ready;
  logic        alu_done;
  logic [15:0] alu_result;
  logic [4:0]  alu_flags;
  logic [15:0] reg_a;
  logic [15:0] reg_b;
  logic [15:0] reg_c;
  logic [4:0]  flags;
  logic [11:0] pc;

  logic [15:0] mem [0:4095];
  logic        tb_ready;
  logic        model_en;
  logic        model_done;
  logic        inj_done;
  int          rd_cnt;
  int          wr_cnt;
  int          hs_cnt;
  logic [11:0] wr_addr;
  logic [15:0] wr_data;
  int          n_cmp;
  int          n_fail;

  cpu_instr_sequencer #(
    .DATA_WIDTH   (16),
    .ADDRESS_WIDTH(12),
    .OPCODE       (4)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .prog_len  (prog_len),
    .busy      (busy),
    .done      (done),
    .mem_addr  (mem_addr),
    .mem_rd_en (mem_rd_en),
    .mem_rdata (mem_rdata),
    .mem_wr_en (mem_wr_en),
    .mem_wdata (mem_wdata),
    .alu_op    (alu_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_done  (alu_done),
    .alu_result(alu_result),
    .alu_flags (alu_flags),
    .reg_a     (reg_a),
    .reg_b     (reg_b),
    .reg_c     (reg_c),
    .flags     (flags),
    .pc        (pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign alu_ready = tb_ready;
  assign alu_done  = model_done | inj_done;

  function automatic logic [20:0] alu_calc(input logic [3:0] op, input logic [15:0] a,
                                           input logic [15:0] b);
    logic [16:0] s;
    logic [15:0] r;
    logic        cy;
    case (op)
      4'h0: begin s = {1'b0, a} + {1'b0, b}; r = s[15:0]; cy = s[16]; end
      4'h1: begin r = a - b; cy = (a < b); end
      default: begin r = a ^ b; cy = 1'b0; end
    endcase
    return {cy, (r == 16'h0), (a == b), (a > b), (a < b), r};
  endfunction

  // Memory read port, ALU model and bus activity counters.
  always @(posedge clk) begin
    if (mem_rd_en) mem_rdata <= mem[mem_addr];
    if (mem_rd_en) rd_cnt <= rd_cnt + 1;
    if (mem_wr_en) begin
      wr_cnt  <= wr_cnt + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
    model_done <= model_en && alu_valid && alu_ready;
    if (alu_valid && alu_ready) begin
      hs_cnt <= hs_cnt + 1;
      {alu_flags, alu_result} <= alu_calc(alu_op, alu_a, alu_b);
    end
  end

  task automatic clear_mem;
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic run_prog(input logic [11:0] len, input int max_cyc,
                          output int done_cyc, output int n_done);
    done_cyc = -1;
    n_done   = 0;
    @(negedge clk);
    prog_len = len;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int c = 1; c <= max_cyc; c++) begin
      @(negedge clk);
      if (done === 1'b1) begin
        n_done++;
        if (done_cyc < 0) done_cyc = c;
      end
      if (done_cyc > 0 && c >= done_cyc + 3) break;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy: got %b want 0", busy); end
    n_cmp++; if (done !== 1'b0) begin n_fail++; $display("FAIL rst_done: got %b want 0", done); end
    n_cmp++; if (pc !== 12'h000) begin n_fail++; $display("FAIL rst_pc: got %h want 000", pc); end
    n_cmp++; if ({reg_a, reg_b, reg_c} !== 48'h0) begin
      n_fail++; $display("FAIL rst_regs: got %h %h %h want 0 0 0", reg_a, reg_b, reg_c);
    end
    n_cmp++; if (flags !== 5'b00000) begin n_fail++; $display("FAIL rst_flags: got %b want 00000", flags); end
    n_cmp++; if ({mem_rd_en, mem_wr_en, alu_valid} !== 3'b000) begin
      n_fail++; $display("FAIL rst_strobes: got %b want 000", {mem_rd_en, mem_wr_en, alu_valid});
    end
    n_cmp++; if (mem_addr !== 12'h000 || alu_op !== 4'h0 || mem_wdata !== 16'h0) begin
      n_fail++; $display("FAIL rst_bus: got addr %h op %h wdata %h want 0", mem_addr, alu_op, mem_wdata);
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_idle: got busy %b want 0", busy); end
  endtask

  task automatic test_load_add;
    int dc, nd;
    clear_mem();
    mem[0] = 16'hD010; mem[1] = 16'hE011; mem[2] = 16'h0000;
    mem[16'h10] = 16'd5; mem[16'h11] = 16'd3;
    run_prog(12'd3, 40, dc, nd);
    n_cmp++; if (dc !== 15) begin n_fail++; $display("FAIL la_done_cycle: got %0d want 15", dc); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL la_done_count: got %0d want 1", nd); end
    n_cmp++; if (reg_a !== 16'd5) begin n_fail++; $display("FAIL la_reg_a: got %h want 0005", reg_a); end
    n_cmp++; if (reg_b !== 16'd3) begin n_fail++; $display("FAIL la_reg_b: got %h want 0003", reg_b); end
    n_cmp++; if (reg_c !== 16'd8) begin n_fail++; $display("FAIL la_reg_c: got %h want 0008", reg_c); end
    n_cmp++; if (pc !== 12'd3) begin n_fail++; $display("FAIL la_pc: got %h want 003", pc); end
    n_cmp++; if (flags !== 5'b00010) begin n_fail++; $display("FAIL la_flags: got %b want 00010", flags); end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL la_busy: got %b want 0", busy); end
  endtask

  task automatic test_held_request;
    int          base_hs;
    bit          seen;
    bit          got_done;
    logic [3:0]  op0;
    logic [15:0] a0, b0;
    mem[0]   = 16'h0000;
    tb_ready = 1'b0;
    base_hs  = hs_cnt;
    @(negedge clk);
    prog_len = 12'd1;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (alu_valid === 1'b1) seen = 1'b1;
    end
    n_cmp++; if (!seen) begin n_fail++; $display("FAIL held_valid: got no alu_valid want 1"); end
    op0 = alu_op; a0 = alu_a; b0 = alu_b;
    n_cmp++; if ({op0, a0, b0} !== {4'h0, 16'd5, 16'd3}) begin
      n_fail++; $display("FAIL held_req: got op %h a %h b %h want 0 0005 0003", op0, a0, b0);
    end
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      n_cmp++;
      if (alu_valid !== 1'b1 || alu_op !== op0 || alu_a !== a0 || alu_b !== b0) begin
        n_fail++;
        $display("FAIL held_stable%0d: got v%b op %h a %h b %h want v1 op %h a %h b %h",
                 i, alu_valid, alu_op, alu_a, alu_b, op0, a0, b0);
      end
    end
    tb_ready = 1'b1;
    got_done = 1'b0;
    for (int i = 0; i < 20 && !got_done; i++) begin
      @(negedge clk);
      if (done === 1'b1) got_done = 1'b1;
    end
    n_cmp++; if (!got_done) begin n_fail++; $display("FAIL held_done: got no done want pulse"); end
    n_cmp++; if (hs_cnt - base_hs !== 1) begin
      n_fail++; $display("FAIL held_handshakes: got %0d want 1", hs_cnt - base_hs);
    end
    n_cmp++; if (reg_c !== 16'd8 || pc !== 12'd1) begin
      n_fail++; $display("FAIL held_result: got c %h pc %h want 0008 001", reg_c, pc);
    end
  endtask

  task automatic test_flags;
    int dc, nd;
    clear_mem();
    mem[0] = 16'hD030; mem[1] = 16'hE030; mem[2] = 16'h1000; mem[3] = 16'hF031;
    mem[16'h30] = 16'd7; mem[16'h31] = 16'h1234;
    run_prog(12'd3, 40, dc, nd);
    n_cmp++; if (flags !== 5'b01100) begin n_fail++; $display("FAIL flg_sub: got %b want 01100", flags); end
    n_cmp++; if (reg_c !== 16'h0000) begin n_fail++; $display("FAIL flg_sub_c: got %h want 0000", reg_c); end
    run_prog(12'd4, 50, dc, nd);
    n_cmp++; if (dc !== 19) begin n_fail++; $display("FAIL flg_done_cycle: got %0d want 19", dc); end
    n_cmp++; if (reg_c !== 16'h1234) begin n_fail++; $display("FAIL flg_loadc: got %h want 1234", reg_c); end
    n_cmp++; if (flags !== 5'b01100) begin n_fail++; $display("FAIL flg_kept: got %b want 01100", flags); end
  endtask

  task automatic test_edge_starts;
    int  dc, nd, base_rd;
    bit  got_done;
    clear_mem();
    base_rd = rd_cnt;
    run_prog(12'd0, 10, dc, nd);
    n_cmp++; if (dc !== 1) begin n_fail++; $display("FAIL zl_done_cycle: got %0d want 1", dc); end
    n_cmp++; if (nd !== 1) begin n_fail++; $display("FAIL zl_done_count: got %0d want 1", nd); end
    n_cmp++; if (rd_cnt - base_rd !== 0) begin
      n_fail++; $display("FAIL zl_reads: got %0d want 0", rd_cnt - base_rd);
    end
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL zl_busy: got %b want 0", busy); end

    mem[0] = 16'hD010; mem[1] = 16'hE011; mem[2] = 16'hF010;
    mem[16'h10] = 16'd5; mem[16'h11] = 16'd3;
    @(negedge clk);
    prog_len = 12'd3;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    dc = -1;
    got_done = 1'b0;
    for (int c = 1; c <= 40 && !got_done; c++) begin
      @(negedge clk);
      if (c == 4) begin start = 1'b1; prog_len = 12'd1; end
      if (c == 6) start = 1'b0;
      if (c == 7) begin
        n_cmp++; if (pc !== 12'd1) begin n_fail++; $display("FAIL busy_start_pc: got %h want 001", pc); end
      end
      if (done === 1'b1) begin got_done = 1'b1; dc = c; end
    end
    start = 1'b0;
    n_cmp++; if (dc !== 13) begin n_fail++; $display("FAIL busy_start_done: got %0d want 13", dc); end
    n_cmp++; if (pc !== 12'd3 || reg_c !== 16'd5) begin
      n_fail++; $display("FAIL busy_start_end: got pc %h c %h want 003 0005", pc, reg_c);
    end
  endtask

  task automatic test_reset_mid;
    bit seen;
    clear_mem();
    mem[0]   = 16'h0000;
    model_en = 1'b0;
    tb_ready = 1'b1;
    @(negedge clk);
    prog_len = 12'd1;
    start    = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (alu_valid === 1'b1) seen = 1'b1;
    end
    @(negedge clk);
    n_cmp++; if (!seen || alu_valid !== 1'b0 || busy !== 1'b1) begin
      n_fail++; $display("FAIL rm_in_wait: got seen %b valid %b busy %b want 1 0 1", seen, alu_valid, busy);
    end
    rst = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rm_busy: got %b want 0", busy); end
    n_cmp++; if ({alu_valid, mem_rd_en, mem_wr_en, done} !== 4'b0000) begin
      n_fail++; $display("FAIL rm_strobes: got %b want 0000", {alu_valid, mem_rd_en, mem_wr_en, done});
    end
    n_cmp++; if ({reg_a, reg_b, reg_c} !== 48'h0) begin
      n_fail++; $display("FAIL rm_regs: got %h %h %h want 0 0 0", reg_a, reg_b, reg_c);
    end
    n_cmp++; if (pc !== 12'h000 || flags !== 5'b00000) begin
      n_fail++; $display("FAIL rm_pc_flags: got pc %h flags %b want 000 00000", pc, flags);
    end
    rst      = 1'b0;
    inj_done = 1'b1;
    @(negedge clk);
    inj_done = 1'b0;
    @(negedge clk);
    n_cmp++; if (reg_c !== 16'h0000 || flags !== 5'b00000 || busy !== 1'b0) begin
      n_fail++; $display("FAIL rm_late_done: got c %h flags %b busy %b want 0000 00000 0", reg_c, flags, busy);
    end
    model_en = 1'b1;
  endtask

  task automatic test_store;
    int dc, nd, base_wr;
    clear_mem();
    mem[0] = 16'hD010; mem[1] = 16'hE011; mem[2] = 16'h0020;
    mem[16'h10] = 16'd5; mem[16'h11] = 16'd3;
    base_wr = wr_cnt;
    run_prog(12'd3, 40, dc, nd);
    n_cmp++; if (reg_c !== 16'd8) begin n_fail++; $display("FAIL st_reg_c: got %h want 0008", reg_c); end
`ifdef CPU_STORE_EN
    n_cmp++; if (wr_cnt - base_wr !== 1) begin
      n_fail++; $display("FAIL st_writes: got %0d want 1", wr_cnt - base_wr);
    end
    n_cmp++; if (wr_addr !== 12'h020 || wr_data !== 16'd8) begin
      n_fail++; $display("FAIL st_write_data: got addr %h data %h want 020 0008", wr_addr, wr_data);
    end
`else
    n_cmp++; if (wr_cnt - base_wr !== 0) begin
      n_fail++; $display("FAIL st_writes: got %0d want 0", wr_cnt - base_wr);
    end
    n_cmp++; if (mem_wdata !== 16'h0000) begin
      n_fail++; $display("FAIL st_wdata: got %h want 0000", mem_wdata);
    end
`endif
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; prog_len = 12'd0;
    tb_ready = 1'b1; model_en = 1'b1; inj_done = 1'b0;
    model_done = 1'b0; alu_result = 16'h0; alu_flags = 5'b0; mem_rdata = 16'h0;
    rd_cnt = 0; wr_cnt = 0; hs_cnt = 0; wr_addr = '0; wr_data = '0;
    n_cmp = 0; n_fail = 0;
    clear_mem();
    test_reset();
    test_load_add();
    test_held_request();
    test_flags();
    test_edge_starts();
    test_reset_mid();
    test_store();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog expired");
  end

endmodule
